// File: rtl/cpu64_obi_arbiter_2to1.sv
// Two-into-one OBI host arbiter with strictly one transaction outstanding.
// Define OBI_ARB_FIXED_PRIO_EN for fixed priority (m1 wins); otherwise round-robin.
module cpu64_obi_arbiter_2to1 #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 39,
    parameter int BE_BITS = DATA_W / 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               m0_req_i,
    input  logic               m0_we_i,
    input  logic [BE_BITS-1:0] m0_be_i,
    input  logic [ADDR_W-1:0]  m0_addr_i,
    input  logic [DATA_W-1:0]  m0_wdata_i,
    output logic               m0_gnt_o,
    output logic               m0_rvalid_o,
    input  logic               m1_req_i,
    input  logic               m1_we_i,
    input  logic [BE_BITS-1:0] m1_be_i,
    input  logic [ADDR_W-1:0]  m1_addr_i,
    input  logic [DATA_W-1:0]  m1_wdata_i,
    output logic               m1_gnt_o,
    output logic               m1_rvalid_o,
    output logic [DATA_W-1:0]  rdata_o,
    output logic               req_o,
    output logic               we_o,
    output logic [BE_BITS-1:0] be_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [DATA_W-1:0]  wdata_o,
    input  logic               gnt_i,
    input  logic               rvalid_i,
    input  logic [DATA_W-1:0]  rdata_i,
    output logic               busy_o
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   rr_q, rr_d;
    logic   lock_q, lock_d;
    logic   locked_sel_q, locked_sel_d;
    logic   arb_sel;
    logic   sel;
    logic   sel_req;

    // A stalled request pins the selection so the bus sees stable OBI signals.
    always_comb begin
        arb_sel = rr_q;
        if (lock_q) begin
            arb_sel = locked_sel_q;
        end else if (m0_req_i && !m1_req_i) begin
            arb_sel = 1'b0;
        end else if (!m0_req_i && m1_req_i) begin
            arb_sel = 1'b1;
        end else if (m0_req_i && m1_req_i) begin
`ifdef OBI_ARB_FIXED_PRIO_EN
            arb_sel = 1'b1;
`else
            arb_sel = rr_q;
`endif
        end
    end

    assign sel     = (state_q == WAIT_RESP) ? owner_q : arb_sel;
    assign sel_req = sel ? m1_req_i : m0_req_i;

    assign req_o   = (state_q == IDLE) && sel_req;
    assign we_o    = sel ? m1_we_i    : m0_we_i;
    assign be_o    = sel ? m1_be_i    : m0_be_i;
    assign addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o = req_o && gnt_i && !sel;
    assign m1_gnt_o = req_o && gnt_i && sel;

    assign m0_rvalid_o = (state_q == WAIT_RESP) && rvalid_i && !owner_q;
    assign m1_rvalid_o = (state_q == WAIT_RESP) && rvalid_i && owner_q;
    assign rdata_o     = rdata_i;
    assign busy_o      = (state_q == WAIT_RESP);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        lock_d       = lock_q;
        locked_sel_d = locked_sel_q;
        case (state_q)
            IDLE: begin
                if (req_o && gnt_i) begin
                    state_d = WAIT_RESP;
                    owner_d = sel;
                    lock_d  = 1'b0;
`ifdef OBI_ARB_FIXED_PRIO_EN
                    rr_d    = 1'b0;
`else
                    rr_d    = ~sel;
`endif
                end else if (req_o) begin
                    lock_d       = 1'b1;
                    locked_sel_d = sel;
                end
            end
            WAIT_RESP: begin
                // Returning to IDLE costs one cycle, so no same-cycle re-grant.
                if (rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            rr_q         <= 1'b0;
            lock_q       <= 1'b0;
            locked_sel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            locked_sel_q <= locked_sel_d;
        end
    end

endmodule

// File: tb/tb_cpu64_obi_arbiter_2to1.sv
// Directed bench for cpu64_obi_arbiter_2to1: reset, routing, round-robin, lock,
// no-turnaround, spurious response and mid-transaction reset.
module tb_cpu64_obi_arbiter_2to1;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 39;
  localparam int BE_BITS = DATA_W / 8;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [BE_BITS-1:0] m0_be_i, m1_be_i, be_o;
  logic [ADDR_W-1:0]  m0_addr_i, m1_addr_i, addr_o;
  logic [DATA_W-1:0]  m0_wdata_i, m1_wdata_i, wdata_o, rdata_o, rdata_i;
  logic               m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic               req_o, we_o, gnt_i, rvalid_i, busy_o;

  int checks = 0;
  int errors = 0;
  logic fixed_prio;
  logic exp_rr;
  logic exp_sel;

  cpu64_obi_arbiter_2to1 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BE_BITS(BE_BITS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .rdata_o(rdata_o), .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .busy_o(busy_o)
  );

  // clock/reset block
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
`ifdef OBI_ARB_FIXED_PRIO_EN
    fixed_prio = 1'b1;
`else
    fixed_prio = 1'b0;
`endif
    m0_req_i = 0; m0_we_i = 0; m0_be_i = 8'hFF; m0_addr_i = '0; m0_wdata_i = 64'h1111;
    m1_req_i = 0; m1_we_i = 1; m1_be_i = 8'h0F; m1_addr_i = '0; m1_wdata_i = 64'h2222;
    gnt_i = 0; rvalid_i = 0; rdata_i = '0;
    do_reset();

    // reset state
    settle();
    check("rst_req", req_o, 0);
    check("rst_m0_gnt", m0_gnt_o, 0);
    check("rst_m1_gnt", m1_gnt_o, 0);
    check("rst_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
    check("rst_busy", busy_o, 0);

    // single m0 transaction with same-cycle grant
    m0_req_i = 1; m0_addr_i = 39'h40; gnt_i = 1;
    settle();
    check("t1_req", req_o, 1);
    check("t1_addr", addr_o, 64'h40);
    check("t1_we", we_o, 0);
    check("t1_be", be_o, 64'hFF);
    check("t1_m0_gnt", m0_gnt_o, 1);
    check("t1_m1_gnt", m1_gnt_o, 0);
    step();
    m0_req_i = 0; gnt_i = 0;
    settle();
    check("t1_busy", busy_o, 1);
    check("t1_req_wait", req_o, 0);
    rvalid_i = 1; rdata_i = 64'hDEAD;
    settle();
    check("t1_m0_rvalid", m0_rvalid_o, 1);
    check("t1_m1_rvalid", m1_rvalid_o, 0);
    check("t1_rdata", rdata_o, 64'hDEAD);
    step();
    rvalid_i = 0;
    exp_rr = 1'b1;
    if (fixed_prio) exp_rr = 1'b0;

    // both requesting, immediate grant and response each round
    m0_req_i = 1; m0_addr_i = 39'h100; m1_req_i = 1; m1_addr_i = 39'h200;
    for (int r = 0; r < 4; r++) begin
      gnt_i = 1;
      exp_sel = fixed_prio ? 1'b1 : exp_rr;
      settle();
      check($sformatf("rr%0d_m0_gnt", r), m0_gnt_o, {63'd0, ~exp_sel});
      check($sformatf("rr%0d_m1_gnt", r), m1_gnt_o, {63'd0, exp_sel});
      check($sformatf("rr%0d_addr", r), addr_o, exp_sel ? 64'h200 : 64'h100);
      step();
      gnt_i = 0; rvalid_i = 1; rdata_i = 64'h5000 + 64'(r);
      settle();
      check($sformatf("rr%0d_rvalid", r), {m1_rvalid_o, m0_rvalid_o}, exp_sel ? 64'd2 : 64'd1);
      step();
      rvalid_i = 0;
      exp_rr = fixed_prio ? 1'b0 : ~exp_sel;
    end
    m0_req_i = 0; m1_req_i = 0;

    // stalled m0 request holds the bus while m1 arrives
    m0_req_i = 1; gnt_i = 0;
    settle();
    check("lk_req", req_o, 1);
    check("lk_addr0", addr_o, 64'h100);
    step();
    m1_req_i = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      check($sformatf("lk%0d_addr", c), addr_o, 64'h100);
      check($sformatf("lk%0d_m1_gnt", c), m1_gnt_o, 0);
      check($sformatf("lk%0d_m0_gnt", c), m0_gnt_o, 0);
      step();
    end
    gnt_i = 1;
    settle();
    check("lk_m0_gnt", m0_gnt_o, 1);
    check("lk_m1_gnt_end", m1_gnt_o, 0);
    check("lk_addr_end", addr_o, 64'h100);
    step();
    gnt_i = 0; m0_req_i = 0; rvalid_i = 1;
    settle();
    check("lk_m0_rvalid", m0_rvalid_o, 1);
    step();
    rvalid_i = 0;

    // m0 waits while m1 owns the bus; no turnaround in the response cycle
    gnt_i = 1;
    settle();
    check("nt_m1_gnt", m1_gnt_o, 1);
    step();
    m1_req_i = 0; m0_req_i = 1;
    for (int c = 0; c < 5; c++) begin
      settle();
      check($sformatf("nt%0d_req", c), req_o, 0);
      check($sformatf("nt%0d_m0_gnt", c), m0_gnt_o, 0);
      check($sformatf("nt%0d_busy", c), busy_o, 1);
      step();
    end
    rvalid_i = 1; rdata_i = 64'hBEEF;
    settle();
    check("nt_m1_rvalid", m1_rvalid_o, 1);
    check("nt_m0_rvalid", m0_rvalid_o, 0);
    check("nt_req_resp", req_o, 0);
    check("nt_m0_gnt_resp", m0_gnt_o, 0);
    step();
    rvalid_i = 0;
    settle();
    check("nt_req_next", req_o, 1);
    check("nt_m0_gnt_next", m0_gnt_o, 1);
    step();
    m0_req_i = 0; gnt_i = 0; rvalid_i = 1;
    step();
    rvalid_i = 0;

    // spurious response in IDLE
    rvalid_i = 1; rdata_i = 64'h77;
    settle();
    check("sp_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
    check("sp_busy", busy_o, 0);
    check("sp_rdata", rdata_o, 64'h77);
    step();
    rvalid_i = 0;
    settle();
    check("sp_busy_after", busy_o, 0);

    // reset while a transaction is outstanding
    m0_req_i = 1; gnt_i = 1;
    step();
    m0_req_i = 0; gnt_i = 0;
    settle();
    check("rs_busy_before", busy_o, 1);
    rst_i = 1;
    step();
    rst_i = 0;
    m1_req_i = 1;
    settle();
    check("rs_busy", busy_o, 0);
    check("rs_req", req_o, 1);
    check("rs_addr", addr_o, 64'h200);
    m1_req_i = 0; rvalid_i = 1;
    settle();
    check("rs_late_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
    step();
    rvalid_i = 0;
    settle();
    check("rs_busy_after", busy_o, 0);

    // preference restored by reset
    m0_req_i = 1; m1_req_i = 1; gnt_i = 1;
    settle();
    check("rs_pref_m0", m0_gnt_o, {63'd0, ~fixed_prio});
    check("rs_pref_m1", m1_gnt_o, {63'd0, fixed_prio});
    step();
    m0_req_i = 0; m1_req_i = 0; gnt_i = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
